// File: rtl/counter_pkg.sv
// Shared definitions for the 4-bit counter family: count width plus the
// wrap-decrement and load-clamp helpers used by the RTL and verification models.
package counter_pkg;

    localparam int CNT_W = 4;

    // Next value of a modulo-'modulus' down count; 0 wraps to modulus-1.
    function automatic logic [CNT_W-1:0] wrap_dec(input logic [CNT_W-1:0] value,
                                                  input logic [CNT_W:0]   modulus);
        logic [CNT_W:0] top;
        top = modulus - 5'd1;
        if (value == '0)
            return top[CNT_W-1:0];
        else
            return value - 4'd1;
    endfunction

    // Load data outside the count range saturates to the top of the range.
    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W:0]   modulus);
        logic [CNT_W:0] top;
        top = modulus - 5'd1;
        if ({1'b0, d} < modulus)
            return d;
        else
            return top[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/counter_4b_down.sv
// Cascadable 4-bit modulo down counter with combinational ripple borrow.
// Optional synchronous parallel load is compiled in with COUNTER_4B_DOWN_LOAD_EN.
module counter_4b_down
    import counter_pkg::*;
#(
    parameter int MODULUS = 16,
    parameter int PRESET  = MODULUS - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic       Bi,
`ifdef COUNTER_4B_DOWN_LOAD_EN
    input  logic       Ld,
    input  logic [3:0] D,
`endif
    output logic       Qa,
    output logic       Qb,
    output logic       Qc,
    output logic       Qd,
    output logic       Rb,
    output logic       Z
);

    localparam logic [CNT_W:0]   MOD_L    = (CNT_W+1)'(MODULUS);
    localparam logic [CNT_W-1:0] PRESET_L = CNT_W'(PRESET);

    logic [CNT_W-1:0] q;
    logic [CNT_W-1:0] q_nxt;
    logic             z;

    always_comb begin
        q_nxt = q;
`ifdef COUNTER_4B_DOWN_LOAD_EN
        if (Ld)
            q_nxt = clamp_load(D, MOD_L);
        else if (En && Bi)
            q_nxt = wrap_dec(q, MOD_L);
`else
        if (En && Bi)
            q_nxt = wrap_dec(q, MOD_L);
`endif
    end

    // Z is registered from the same next value so it always tracks Q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= PRESET_L;
            z <= (PRESET_L == '0);
        end else begin
            q <= q_nxt;
            z <= (q_nxt == '0);
        end
    end

    assign Rb = En & Bi & (q == '0);
    assign Z  = z;
    assign Qa = q[0];
    assign Qb = q[1];
    assign Qc = q[2];
    assign Qd = q[3];

endmodule

// File: tb/tb_counter_4b_down.sv
// Self-checking bench for counter_4b_down: a 16-state stage plus a two-digit
// MODULUS=10 cascade, checked every cycle against a modular-arithmetic model.
module tb_counter_4b_down;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en16 = 1'b0, bi16 = 1'b0, ld16 = 1'b0;
    logic [3:0] d16 = 4'd0;
    logic       en10 = 1'b0, ld10 = 1'b0;
    logic [3:0] d10 = 4'd0;
    logic       ld_zero = 1'b0;
    logic [3:0] d_zero = 4'd0;
    logic       bi_one = 1'b1;

    wire qa16, qb16, qc16, qd16, rb16, z16;
    wire qaa, qba, qca, qda, rba, za;
    wire qab, qbb, qcb, qdb, rbb, zb;
    wire [3:0] q16  = {qd16, qc16, qb16, qa16};
    wire [3:0] q10a = {qda, qca, qba, qaa};
    wire [3:0] q10b = {qdb, qcb, qbb, qab};

    counter_4b_down u16 (
        .clk(clk), .rst(rst), .En(en16), .Bi(bi16),
`ifdef COUNTER_4B_DOWN_LOAD_EN
        .Ld(ld16), .D(d16),
`endif
        .Qa(qa16), .Qb(qb16), .Qc(qc16), .Qd(qd16), .Rb(rb16), .Z(z16)
    );

    counter_4b_down #(.MODULUS(10), .PRESET(9)) u10a (
        .clk(clk), .rst(rst), .En(en10), .Bi(bi_one),
`ifdef COUNTER_4B_DOWN_LOAD_EN
        .Ld(ld10), .D(d10),
`endif
        .Qa(qaa), .Qb(qba), .Qc(qca), .Qd(qda), .Rb(rba), .Z(za)
    );

    counter_4b_down #(.MODULUS(10), .PRESET(9)) u10b (
        .clk(clk), .rst(rst), .En(en10), .Bi(rba),
`ifdef COUNTER_4B_DOWN_LOAD_EN
        .Ld(ld_zero), .D(d_zero),
`endif
        .Qa(qab), .Qb(qbb), .Qc(qcb), .Qd(qdb), .Rb(rbb), .Z(zb)
    );

`ifdef COUNTER_4B_DOWN_LOAD_EN
    localparam bit LOAD_ON = 1'b1;
`else
    localparam bit LOAD_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    int m16 = 0, m10a = 0, m10b = 0;

    function automatic int model_next(int q, int m, int p, bit r, bit ld, int d, bit cnt);
        if (r)        return p;
        if (ld)       return (d < m) ? d : m - 1;
        if (cnt)      return (q + m - 1) % m;
        return q;
    endfunction

    always @(posedge clk) begin
        m16  <= model_next(m16, 16, 15, rst, LOAD_ON & ld16, int'(d16), en16 & bi16);
        m10a <= model_next(m10a, 10, 9, rst, LOAD_ON & ld10, int'(d10), en10);
        m10b <= model_next(m10b, 10, 9, rst, 1'b0, 0, en10 & (m10a == 0));
    end

    always @(negedge clk) begin
        chk("q16",  {1'b0, q16},  5'(m16));
        chk("z16",  {4'b0, z16},  5'(m16 == 0));
        chk("rb16", {4'b0, rb16}, 5'(en16 & bi16 & (m16 == 0)));
        chk("q10a", {1'b0, q10a}, 5'(m10a));
        chk("z10a", {4'b0, za},   5'(m10a == 0));
        chk("rb10a", {4'b0, rba}, 5'(en10 & (m10a == 0)));
        chk("q10b", {1'b0, q10b}, 5'(m10b));
        chk("z10b", {4'b0, zb},   5'(m10b == 0));
        chk("rb10b", {4'b0, rbb}, 5'(en10 & (m10a == 0) & (m10b == 0)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int changes;
        logic [3:0] prev;

        tick();
        chk("rst_q16", {1'b0, q16}, 5'd15);
        chk("rst_z16", {4'b0, z16}, 5'd0);
        chk("rst_rb16", {4'b0, rb16}, 5'd0);
        chk("rst_q10a", {1'b0, q10a}, 5'd9);
        chk("rst_q10b", {1'b0, q10b}, 5'd9);

        rst = 1'b0; en16 = 1'b1; bi16 = 1'b1;
        repeat (15) tick();
        chk("cd_q0", {1'b0, q16}, 5'd0);
        chk("cd_z0", {4'b0, z16}, 5'd1);
        chk("cd_rb0", {4'b0, rb16}, 5'd1);
        tick();
        chk("cd_wrap", {1'b0, q16}, 5'd15);
        chk("cd_z_wrap", {4'b0, z16}, 5'd0);

        repeat (12) tick();
        chk("to3", {1'b0, q16}, 5'd3);
        bi16 = 1'b0;
        repeat (5) tick();
        chk("hold_bi", {1'b0, q16}, 5'd3);
        chk("hold_bi_rb", {4'b0, rb16}, 5'd0);
        en16 = 1'b0; bi16 = 1'b1;
        repeat (5) tick();
        chk("hold_en", {1'b0, q16}, 5'd3);

        en10 = 1'b1;
        changes = 0;
        for (int i = 1; i <= 100; i++) begin
            prev = q10b;
            tick();
            if (q10b !== prev) changes++;
            if (i == 10) begin
                chk("casc10_a", {1'b0, q10a}, 5'd9);
                chk("casc10_b", {1'b0, q10b}, 5'd8);
            end
        end
        chk("casc100_a", {1'b0, q10a}, 5'd9);
        chk("casc100_b", {1'b0, q10b}, 5'd9);
        chk("casc_steps", 5'(changes), 5'd10);
        en10 = 1'b0;

        en16 = 1'b1; bi16 = 1'b1;
        repeat (12) tick();
        chk("to7", {1'b0, q16}, 5'd7);
        rst = 1'b1; ld16 = 1'b1; d16 = 4'd2;
        tick();
        chk("rst_mid", {1'b0, q16}, 5'd15);
        rst = 1'b0; ld16 = 1'b0; en16 = 1'b0;

`ifdef COUNTER_4B_DOWN_LOAD_EN
        en10 = 1'b1; ld10 = 1'b1; d10 = 4'd5;
        tick();
        chk("ld5", {1'b0, q10a}, 5'd5);
        d10 = 4'd12;
        tick();
        chk("ld_clamp", {1'b0, q10a}, 5'd9);
        ld10 = 1'b0; en10 = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 29) == 0);
            en16 = $urandom_range(0, 3) != 0;
            bi16 = $urandom_range(0, 3) != 0;
            ld16 = ($urandom_range(0, 9) == 0);
            d16  = 4'($urandom_range(0, 15));
            en10 = $urandom_range(0, 4) != 0;
            ld10 = ($urandom_range(0, 14) == 0);
            d10  = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; en16 = 1'b0; en10 = 1'b0; ld16 = 1'b0; ld10 = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
